// File: rtl/rate_ctrl_sched.sv
`default_nettype none
// ============================================================================
// Module   : rate_ctrl_sched
// Purpose  : Rate controller and tick scheduler for the LED/display timebase.
//            Owns the 2-bit rate selection, runs the half-period divider and
//            defers rate changes to the next half-period boundary so the
//            square-wave output never carries a runt pulse.
// Ports    : iClk          - system clock
//            iRst          - synchronous active-high reset
//            iFaster       - 1-cycle pulse, request next higher rate
//            iSlower       - 1-cycle pulse, request next lower rate
//            iPause        - 1-cycle pulse, toggle pause
//            oRate_control - applied rate (0..2)
//            oClk          - registered square wave
//            oTick         - 1-cycle pulse on every oClk edge
//            oPending      - rate change waiting for the next boundary
//            oPaused       - block is paused
// Revision : 1.0 - initial release
// ============================================================================
module rate_ctrl_sched #(
    parameter int unsigned DIV0  = 50_000_000,
    parameter int unsigned DIV1  = 10_000_000,
    parameter int unsigned DIV2  = 5_000_000,
    parameter int unsigned CNT_W = 32
) (
    input  logic       iClk,
    input  logic       iRst,
    input  logic       iFaster,
    input  logic       iSlower,
    input  logic       iPause,
    output logic [1:0] oRate_control,
    output logic       oClk,
    output logic       oTick,
    output logic       oPending,
    output logic       oPaused
);

    // Terminal-count values for each rate
    localparam logic [CNT_W-1:0] c_TC0 = CNT_W'(DIV0 - 1);
    localparam logic [CNT_W-1:0] c_TC1 = CNT_W'(DIV1 - 1);
    localparam logic [CNT_W-1:0] c_TC2 = CNT_W'(DIV2 - 1);
    localparam logic [CNT_W-1:0] c_ONE = CNT_W'(1);

    typedef enum logic [1:0] {
        S_RUN    = 2'd0,
        S_PEND   = 2'd1,
        S_PAUSED = 2'd2
    } state_t;

    state_t           r_state, w_state_n;
    logic [CNT_W-1:0] r_cnt,   w_cnt_n;
    logic             r_clk,   w_clk_n;
    logic             r_tick,  w_tick_n;
    logic [1:0]       r_rate,  w_rate_n;
    logic [1:0]       r_target, w_target_n;

    logic [CNT_W-1:0] w_tc_val;
    logic             w_tc;
    logic             w_valid;
    logic [1:0]       w_base;
    logic [1:0]       w_req_target;

    // Divider terminal count follows the applied rate only
    always_comb begin
        case (r_rate)
            2'd0:    w_tc_val = c_TC0;
            2'd1:    w_tc_val = c_TC1;
            default: w_tc_val = c_TC2;
        endcase
    end

    assign w_tc    = (r_cnt == w_tc_val);
    assign w_valid = iFaster ^ iSlower;

    // While a change is pending, further requests step from the pending
    // target so that the most recent request wins.
    assign w_base = (r_state == S_PEND) ? r_target : r_rate;

    always_comb begin
        if (iFaster) begin
            w_req_target = (w_base >= 2'd2) ? 2'd2 : w_base + 2'd1;
        end else begin
            w_req_target = (w_base == 2'd0) ? 2'd0 : w_base - 2'd1;
        end
    end

    always_comb begin
        w_state_n  = r_state;
        w_cnt_n    = r_cnt;
        w_clk_n    = r_clk;
        w_tick_n   = 1'b0;
        w_rate_n   = r_rate;
        w_target_n = r_target;

        case (r_state)
            S_RUN: begin
                if (iPause) begin
                    // Counter and oClk freeze from this edge; request dropped
                    w_state_n = S_PAUSED;
                end else begin
                    if (w_tc) begin
                        w_cnt_n  = '0;
                        w_clk_n  = ~r_clk;
                        w_tick_n = 1'b1;
                    end else begin
                        w_cnt_n = r_cnt + c_ONE;
                    end
                    if (w_valid && (w_req_target != r_rate)) begin
                        w_target_n = w_req_target;
                        w_state_n  = S_PEND;
                    end
                end
            end

            S_PEND: begin
                if (iPause) begin
                    // A pending change does not survive a pause
                    w_state_n  = S_PAUSED;
                    w_target_n = r_rate;
                end else if (w_tc) begin
                    // Boundary: toggle with the old rate, then adopt the
                    // pending target. A request on this same edge steps from
                    // the pre-update target, which is now the applied rate.
                    w_cnt_n  = '0;
                    w_clk_n  = ~r_clk;
                    w_tick_n = 1'b1;
                    w_rate_n = r_target;
                    if (w_valid && (w_req_target != r_target)) begin
                        w_target_n = w_req_target;
                        w_state_n  = S_PEND;
                    end else begin
                        w_state_n  = S_RUN;
                    end
                end else begin
                    w_cnt_n = r_cnt + c_ONE;
                    if (w_valid) begin
                        w_target_n = w_req_target;
                        if (w_req_target == r_rate) begin
                            w_state_n = S_RUN;
                        end
                    end
                end
            end

            S_PAUSED: begin
                if (w_valid) begin
                    w_rate_n   = w_req_target;
                    w_target_n = w_req_target;
                    if (w_req_target != r_rate) begin
                        w_cnt_n = '0;
                    end
                end
                if (iPause) begin
                    w_state_n = S_RUN;
                end
            end

            default: begin
                w_state_n = S_RUN;
            end
        endcase
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            r_state  <= S_RUN;
            r_cnt    <= '0;
            r_clk    <= 1'b0;
            r_tick   <= 1'b0;
            r_rate   <= 2'd0;
            r_target <= 2'd0;
        end else begin
            r_state  <= w_state_n;
            r_cnt    <= w_cnt_n;
            r_clk    <= w_clk_n;
            r_tick   <= w_tick_n;
            r_rate   <= w_rate_n;
            r_target <= w_target_n;
        end
    end

    assign oRate_control = r_rate;
    assign oClk          = r_clk;
    assign oTick         = r_tick;
    assign oPending      = (r_state == S_PEND);
    assign oPaused       = (r_state == S_PAUSED);

endmodule
`default_nettype wire

// File: tb/tb_rate_ctrl_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_rate_ctrl_sched
// Purpose  : Directed self-checking bench for rate_ctrl_sched with
//            DIV0=8, DIV1=4, DIV2=2.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rate_ctrl_sched;

    logic       clk;
    logic       rst;
    logic       faster;
    logic       slower;
    logic       pause;
    logic [1:0] rate;
    logic       sq;
    logic       tick;
    logic       pending;
    logic       paused;

    int checks = 0;
    int errors = 0;

    rate_ctrl_sched #(
        .DIV0  (8),
        .DIV1  (4),
        .DIV2  (2),
        .CNT_W (32)
    ) u_dut (
        .iClk          (clk),
        .iRst          (rst),
        .iFaster       (faster),
        .iSlower       (slower),
        .iPause        (pause),
        .oRate_control (rate),
        .oClk          (sq),
        .oTick         (tick),
        .oPending      (pending),
        .oPaused       (paused)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance one clock edge, landing 1 time unit after it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Count edges until oTick is seen, bounded by max
    task automatic wait_tick(input int max, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!tick && n < max);
    endtask

    int  n;
    bit  saw_tick;
    bit  clk_moved;

    initial begin
        rst = 1'b1; faster = 1'b0; slower = 1'b0; pause = 1'b0;
        steps(3);

        // ---- Reset state
        chk("rst_rate",    32'(rate),    32'd0);
        chk("rst_clk",     32'(sq),      32'd0);
        chk("rst_tick",    32'(tick),    32'd0);
        chk("rst_pending", 32'(pending), 32'd0);
        chk("rst_paused",  32'(paused),  32'd0);

        // ---- Free-run at rate 0: half-period 8
        rst = 1'b0;
        wait_tick(40, n);
        chk("first_tick_lat", 32'(n), 32'd8);
        chk("first_rise",     32'(sq), 32'd1);
        wait_tick(40, n);
        chk("half_period_0",  32'(n), 32'd8);
        chk("fall_0",         32'(sq), 32'd0);
        chk("rate_0",         32'(rate), 32'd0);
        chk("pend_0",         32'(pending), 32'd0);

        // ---- Deferred change: faster at count 3
        steps(3);
        faster = 1'b1; step(); faster = 1'b0;
        chk("defer_pending", 32'(pending), 32'd1);
        chk("defer_rate_old", 32'(rate),   32'd0);
        wait_tick(40, n);
        chk("defer_lat",     32'(n), 32'd4);
        chk("defer_rate_new", 32'(rate),   32'd1);
        chk("defer_pend_clr", 32'(pending), 32'd0);
        chk("defer_rise",    32'(sq), 32'd1);
        wait_tick(40, n);
        chk("half_period_1", 32'(n), 32'd4);
        chk("fall_1",        32'(sq), 32'd0);

        // ---- Simultaneous requests ignored
        faster = 1'b1; slower = 1'b1; step(); faster = 1'b0; slower = 1'b0;
        chk("both_pending", 32'(pending), 32'd0);

        // ---- Cancel in PEND: faster then slower from rate 1
        faster = 1'b1; step(); faster = 1'b0;
        chk("cancel_pend_set", 32'(pending), 32'd1);
        slower = 1'b1; step(); slower = 1'b0;
        chk("cancel_pend_clr", 32'(pending), 32'd0);
        chk("cancel_rate",     32'(rate),    32'd1);
        wait_tick(40, n);
        chk("cancel_tick_lat", 32'(n), 32'd1);
        chk("cancel_rate_bnd", 32'(rate), 32'd1);

        // ---- Three faster pulses from rate 1 saturate at 2
        for (int i = 0; i < 3; i++) begin
            faster = 1'b1; step(); faster = 1'b0;
        end
        chk("sat_pending", 32'(pending), 32'd1);
        chk("sat_rate_old", 32'(rate),   32'd1);
        wait_tick(40, n);
        chk("sat_lat",     32'(n), 32'd1);
        chk("sat_rate",    32'(rate), 32'd2);
        wait_tick(40, n);
        chk("half_period_2", 32'(n), 32'd2);
        chk("sat_rate_hold", 32'(rate), 32'd2);
        chk("rise_2",        32'(sq), 32'd1);

        // ---- Request in the terminal-count cycle of PEND
        slower = 1'b1; step();
        chk("tc_req_pending0", 32'(pending), 32'd1);
        step(); slower = 1'b0;
        chk("tc_req_tick",    32'(tick),    32'd1);
        chk("tc_req_rate",    32'(rate),    32'd1);
        chk("tc_req_pending", 32'(pending), 32'd1);
        wait_tick(40, n);
        chk("tc_req_lat",     32'(n), 32'd4);
        chk("tc_req_rate2",   32'(rate), 32'd0);
        chk("tc_req_pendclr", 32'(pending), 32'd0);
        wait_tick(40, n);
        chk("back_to_div0",   32'(n), 32'd8);

        // ---- Slower at rate 0 saturates: nothing pending
        slower = 1'b1; step(); slower = 1'b0;
        chk("sat_low_pending", 32'(pending), 32'd0);
        chk("sat_low_rate",    32'(rate),    32'd0);

        // ---- Latest wins: faster, faster from rate 0 -> 2
        faster = 1'b1; step(); faster = 1'b0;
        faster = 1'b1; step(); faster = 1'b0;
        chk("latest_pending", 32'(pending), 32'd1);
        wait_tick(40, n);
        chk("latest_lat",  32'(n), 32'd5);
        chk("latest_rate", 32'(rate), 32'd2);
        chk("latest_rise", 32'(sq), 32'd1);

        // ---- Reset mid-PEND
        slower = 1'b1; step(); slower = 1'b0;
        chk("mid_pend_set", 32'(pending), 32'd1);
        rst = 1'b1; step(); rst = 1'b0;
        chk("mid_rst_rate",    32'(rate),    32'd0);
        chk("mid_rst_clk",     32'(sq),      32'd0);
        chk("mid_rst_tick",    32'(tick),    32'd0);
        chk("mid_rst_pending", 32'(pending), 32'd0);
        chk("mid_rst_paused",  32'(paused),  32'd0);
        wait_tick(40, n);
        chk("mid_rst_lat",  32'(n), 32'd8);
        chk("mid_rst_rate2", 32'(rate), 32'd0);

        // ---- Pause at count 5, hold 20 cycles
        steps(5);
        pause = 1'b1; step(); pause = 1'b0;
        chk("pause_flag", 32'(paused), 32'd1);
        saw_tick = 1'b0; clk_moved = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (tick) saw_tick = 1'b1;
            if (sq !== 1'b1) clk_moved = 1'b1;
        end
        chk("pause_no_tick", 32'(saw_tick),  32'd0);
        chk("pause_clk_hold", 32'(clk_moved), 32'd0);

        // Request while paused applies at once and clears the counter
        faster = 1'b1; step(); faster = 1'b0;
        chk("pause_req_rate",   32'(rate),    32'd1);
        chk("pause_req_paused", 32'(paused),  32'd1);
        chk("pause_req_pend",   32'(pending), 32'd0);
        pause = 1'b1; step(); pause = 1'b0;
        chk("resume_flag", 32'(paused), 32'd0);
        wait_tick(40, n);
        chk("resume_lat", 32'(n), 32'd4);
        chk("resume_fall", 32'(sq), 32'd0);

        // ---- Pause+request together in RUN: request dropped; resume from frozen count
        steps(2);
        pause = 1'b1; faster = 1'b1; step(); pause = 1'b0; faster = 1'b0;
        chk("pause_prio_rate",   32'(rate),   32'd1);
        chk("pause_prio_paused", 32'(paused), 32'd1);
        steps(3);
        pause = 1'b1; step(); pause = 1'b0;
        wait_tick(40, n);
        chk("frozen_resume_lat", 32'(n), 32'd2);
        chk("frozen_resume_clk", 32'(sq), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rate_ctrl_sched.md
# rate_ctrl_sched

Rate controller and tick scheduler for the LED/display timebase. Accepts single-cycle faster/slower/pause requests (from debounced push-buttons), owns the 2-bit rate selection, and runs the half-period divider itself. Rate changes are deferred to the next half-period boundary so the output square wave never produces a runt pulse. Downstream logic consumes either the square wave `oClk` or the single-cycle enable `oTick`.

## Interface

**Parameters**
- `DIV0`, default 50_000_000: half-period in `iClk` cycles for rate 0 (1 Hz at 100 MHz).
- `DIV1`, default 10_000_000: half-period for rate 1 (5 Hz).
- `DIV2`, default 5_000_000: half-period for rate 2 (10 Hz).
- `CNT_W`, default 32: counter width; each `DIVn` must satisfy 2 ≤ `DIVn` < 2^`CNT_W`.

**Ports**
- `iClk` in 1: single system clock, 100 MHz.
- `iRst` in 1: synchronous, active-high reset.
- `iFaster` in 1: one-cycle pulse requesting the next higher rate.
- `iSlower` in 1: one-cycle pulse requesting the next lower rate.
- `iPause` in 1: one-cycle pulse that toggles pause.
- `oRate_control` out 2: applied rate; 0, 1 or 2, never 3.
- `oClk` out 1: square wave, registered.
- `oTick` out 1: one-cycle pulse on every `oClk` edge.
- `oPending` out 1: a rate change is waiting for the next boundary.
- `oPaused` out 1: block is in the PAUSED state.

## Operation

- **Reset values:** `oRate_control`=0, `oClk`=0, `oTick`=0, `oPending`=0, `oPaused`=0, counter=0, pending target=0. Reset wins over every other input in the same cycle. Reset mid-operation discards any pending change.
- **States:** RUN, PEND, PAUSED.
- **Divider:** the counter counts from 0 to `DIVsel`-1, where `DIVsel` is selected by the applied rate. At terminal count:
  - counter returns to 0,
  - `oClk` toggles,
  - `oTick` is 1 for the following cycle.
  - `oTick` is 0 at all other times.
- **Requests:** a request is valid when exactly one of `iFaster`/`iSlower` is high. When both are high in the same cycle, both are ignored.
- **Target computation:** target = base+1 for faster, base-1 for slower, saturating at 0 and 2. Base is the applied rate in RUN and the pending target in PEND.
- **RUN:**
  - A valid request whose target differs from the applied rate stores the target and goes to PEND, with `oPending`=1 on the next cycle.
  - A saturated request (target equals applied rate) is ignored and the state stays RUN.
- **PEND:**
  - Further valid requests update the pending target; the latest request wins.
  - If the target returns to the applied rate, the block goes back to RUN and clears `oPending`.
  - At terminal count, the toggle and tick occur with the old rate. On the same edge, `oRate_control` takes the target, the counter clears, and `oPending` clears. The next half-period uses the new `DIVsel`.
  - A request arriving in the terminal-count cycle is evaluated against the pre-update target, and the counter still clears.
- **Pause:**
  - `iPause` in RUN or PEND enters PAUSED. The counter and `oClk` freeze, `oTick` is 0, and `oPaused`=1.
  - `iPause` has priority over a rate request in the same cycle; that request is dropped.
- **PAUSED:**
  - Valid requests apply to `oRate_control` immediately, clear the counter, and clear any pending change.
  - `iPause` returns to RUN, and counting resumes from the frozen count, or from 0 if the rate changed while paused.
  - A rate request together with `iPause` in PAUSED: the rate is applied and the block resumes.

## Timing

- All outputs are registered; there is no combinational input-to-output path.
- First `oClk` rise and `oTick` occur `DIV0` cycles after the first cycle with `iRst`=0. The `oClk` period is 2·`DIVsel` cycles.
- Request to `oPending` latency: 1 cycle.
- Request to `oRate_control` latency: the remaining cycles to terminal count plus 1.
- In PAUSED, request to `oRate_control` latency: 1 cycle.
- `iPause` to `oPaused` latency: 1 cycle. The counter holds from the edge on which `oPaused` rises.
- Between any two consecutive `oClk` edges there are exactly `DIVsel` cycles of a single rate; there are no runt pulses.

## Test plan

All scenarios use `DIV0`=8, `DIV1`=4, `DIV2`=2.

1. **Reset and free-run:** release reset -> first `oTick` and `oClk` rise 8 cycles later, period 16, `oRate_control`=0, `oPending`=0.
2. **Deferred change:** `iFaster` at count 3 -> `oPending`=1 next cycle; `oRate_control`=1 on the edge after count 7. Subsequent half-periods are 4 cycles and `oPending`=0.
3. **Saturation and simultaneous requests:**
   - `iSlower` at rate 0 -> no change, `oPending` stays 0.
   - `iFaster`+`iSlower` together -> ignored.
   - Three `iFaster` pulses, then wait -> the rate settles at 2, never 3.
4. **Latest-wins and cancel in PEND:**
   - From rate 0, `iFaster`, `iFaster` -> applied rate 2 at the boundary.
   - From rate 1, `iFaster` then `iSlower` -> `oPending` clears and the rate stays 1.
5. **Pause:**
   - `iPause` at count 5 -> `oClk` and counter frozen for 20 cycles, `oTick`=0.
   - `iSlower` while paused -> rate changes next cycle and the counter clears.
   - `iPause` -> resume; next tick after the new `DIVsel`.
6. **Reset mid-PEND:** assert `iRst` while `oPending`=1 -> all outputs return to reset values next cycle and the pending target is discarded.
